// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 2-cycle barrel shifter between two issue lanes.
// Tracks in-flight ops and returns each result tagged with requester id and tag.
module shift_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_value,
    input  logic [1:0]       req0_kind,
    input  logic [5:0]       req0_shamt,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_value,
    input  logic [1:0]       req1_kind,
    input  logic [5:0]       req1_shamt,
    input  logic [TAG_W-1:0] req1_tag,
    input  logic             flush,
    output logic [63:0]      sh_value,
    output logic [1:0]       sh_kind,
    output logic [5:0]       sh_shift,
    input  logic [63:0]      sh_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      rsp_data,
    output logic             busy
);

    logic             ptr_q;
    logic             gnt0;
    logic             gnt1;
    logic             accept;

    logic             v1_q;
    logic             id1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [1:0]       kind1_q;
    logic [5:0]       shamt1_q;

    logic             v2_q;
    logic             id2_q;
    logic [TAG_W-1:0] tag2_q;

    // Grant is suppressed during reset so nothing is handshaken or driven to the shifter.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign accept     = (gnt0 | gnt1) & ~flush;
    assign req0_ready = gnt0 & ~flush;
    assign req1_ready = gnt1 & ~flush;

    // The shifter captures the operand at the issue edge, so it is presented in the grant cycle.
    always_comb begin
        sh_value = '0;
        if (gnt1) begin
            sh_value = req1_value;
        end else if (gnt0) begin
            sh_value = req0_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            v1_q     <= 1'b0;
            id1_q    <= 1'b0;
            tag1_q   <= '0;
            kind1_q  <= '0;
            shamt1_q <= '0;
            v2_q     <= 1'b0;
            id2_q    <= 1'b0;
            tag2_q   <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                ptr_q    <= gnt0;
                id1_q    <= gnt1;
                tag1_q   <= gnt1 ? req1_tag   : req0_tag;
                kind1_q  <= gnt1 ? req1_kind  : req0_kind;
                shamt1_q <= gnt1 ? req1_shamt : req0_shamt;
            end
            v2_q   <= v1_q & ~flush;
            id2_q  <= id1_q;
            tag2_q <= tag1_q;
        end
    end

    // Idle stage 1 presents a pass-through op so the shifter result is benign.
    assign sh_kind   = v1_q ? kind1_q  : 2'b11;
    assign sh_shift  = v1_q ? shamt1_q : 6'd0;

    assign rsp_valid = v2_q;
    assign rsp_id    = id2_q;
    assign rsp_tag   = tag2_q;
    assign rsp_data  = sh_result;
    assign busy      = v1_q | v2_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: shifter environment model plus a queue-based reference of
// expected responses, driven by directed scenarios followed by random traffic.
module tb_shift_arbiter;

    localparam int unsigned TAG_W = 4;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    logic             lv    [2];
    logic [63:0]      lval  [2];
    logic [1:0]       lkind [2];
    logic [5:0]       lsh   [2];
    logic [TAG_W-1:0] ltag  [2];
    logic             acc   [2];

    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0]      req0_value, req1_value;
    logic [1:0]       req0_kind, req1_kind;
    logic [5:0]       req0_shamt, req1_shamt;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [63:0]      sh_value, sh_result, rsp_data;
    logic [1:0]       sh_kind;
    logic [5:0]       sh_shift;
    logic             rsp_valid, rsp_id, busy;
    logic [TAG_W-1:0] rsp_tag;

    assign req0_valid = lv[0];
    assign req0_value = lval[0];
    assign req0_kind  = lkind[0];
    assign req0_shamt = lsh[0];
    assign req0_tag   = ltag[0];
    assign req1_valid = lv[1];
    assign req1_value = lval[1];
    assign req1_kind  = lkind[1];
    assign req1_shamt = lsh[1];
    assign req1_tag   = ltag[1];

    shift_arbiter #(.TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_value (req0_value),
        .req0_kind  (req0_kind),
        .req0_shamt (req0_shamt),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_value (req1_value),
        .req1_kind  (req1_kind),
        .req1_shamt (req1_shamt),
        .req1_tag   (req1_tag),
        .flush      (flush),
        .sh_value   (sh_value),
        .sh_kind    (sh_kind),
        .sh_shift   (sh_shift),
        .sh_result  (sh_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    function automatic logic [63:0] shift_ref(input logic [63:0] v, input logic [1:0] k,
                                              input logic [5:0] s);
        case (k)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return 64'($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    // External shifter: operand registered at issue, kind/shift used the next cycle.
    logic [63:0] sh_op_q, sh_res_q;
    always_ff @(posedge clock) begin
        sh_op_q  <= sh_value;
        sh_res_q <= shift_ref(sh_op_q, sh_kind, sh_shift);
    end
    assign sh_result = sh_res_q;

    typedef struct {
        int               due;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [1:0]       kind;
        logic [5:0]       sh;
        logic [63:0]      data;
    } exp_t;

    exp_t pend[$];
    logic m_ptr;
    int   cyc;
    int   n_checks;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_lane(input int l, input logic [63:0] v, input logic [1:0] k,
                            input logic [5:0] s, input logic [TAG_W-1:0] t);
        lv[l] = 1'b1; lval[l] = v; lkind[l] = k; lsh[l] = s; ltag[l] = t;
    endtask

    task automatic settle();
        #3;
    endtask

    // Compare this cycle against the reference, then apply the coming edge to it.
    task automatic eval_and_advance();
        int   g;
        int   i_now;
        int   i_nxt;
        logic e0;
        logic e1;
        exp_t e;
        g = -1;
        if (!reset) begin
            if (lv[0] && lv[1]) g = m_ptr ? 1 : 0;
            else if (lv[0])     g = 0;
            else if (lv[1])     g = 1;
        end
        e0 = (g == 0) && !flush;
        e1 = (g == 1) && !flush;
        check("req0_ready", 64'(req0_ready), 64'(e0));
        check("req1_ready", 64'(req1_ready), 64'(e1));
        if (!reset) begin
            if (g >= 0) check("sh_value", sh_value, lval[g]);
            else        check("sh_value_idle", sh_value, 64'd0);
            i_now = -1;
            i_nxt = -1;
            foreach (pend[k]) begin
                if (pend[k].due == cyc)     i_now = k;
                if (pend[k].due == cyc + 1) i_nxt = k;
            end
            check("rsp_valid", 64'(rsp_valid), 64'(i_now >= 0));
            if (i_now >= 0) begin
                check("rsp_id",   64'(rsp_id),  64'(pend[i_now].id));
                check("rsp_tag",  64'(rsp_tag), 64'(pend[i_now].tag));
                check("rsp_data", rsp_data,     pend[i_now].data);
            end
            if (i_nxt >= 0) begin
                check("sh_kind",  64'(sh_kind),  64'(pend[i_nxt].kind));
                check("sh_shift", 64'(sh_shift), 64'(pend[i_nxt].sh));
            end else begin
                check("sh_kind_idle",  64'(sh_kind),  64'(2'b11));
                check("sh_shift_idle", 64'(sh_shift), 64'd0);
            end
            check("busy", 64'(busy), 64'(i_now >= 0 || i_nxt >= 0));
        end
        if (reset) begin
            pend.delete();
            m_ptr = 1'b0;
        end else begin
            for (int k = pend.size() - 1; k >= 0; k--) begin
                if (pend[k].due == cyc || (flush && pend[k].due == cyc + 1)) pend.delete(k);
            end
            if (!flush && g >= 0) begin
                e.due  = cyc + 2;
                e.id   = (g == 1);
                e.tag  = ltag[g];
                e.kind = lkind[g];
                e.sh   = lsh[g];
                e.data = shift_ref(lval[g], lkind[g], lsh[g]);
                pend.push_back(e);
                m_ptr = (g == 0);
            end
        end
        acc[0] = e0;
        acc[1] = e1;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        settle();
        eval_and_advance();
    endtask

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'h8000_0000_0000_0000 | {32'h0, $urandom};
            2:       return 64'd1;
            default: return '1;
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        m_ptr    = 1'b0;
        reset    = 1'b1;
        flush    = 1'b0;
        for (int l = 0; l < 2; l++) begin
            lv[l] = 1'b0; lval[l] = '0; lkind[l] = '0; lsh[l] = '0; ltag[l] = '0; acc[l] = 1'b0;
        end
        @(posedge clock);
        #1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_sh_kind", 64'(sh_kind), 64'(2'b11));
        check("rst_busy", 64'(busy), 64'd0);
        eval_and_advance();

        // Single sll op through the pipeline.
        set_lane(0, 64'h1, 2'b00, 6'd4, 4'd3);
        settle(); check("t1_ready", 64'(req0_ready), 64'd1); eval_and_advance();
        lv[0] = 1'b0;
        settle();
        check("t1_kind", 64'(sh_kind), 64'd0);
        check("t1_shift", 64'(sh_shift), 64'd4);
        check("t1_early", 64'(rsp_valid), 64'd0);
        eval_and_advance();
        settle();
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_data", rsp_data, 64'h10);
        check("t1_tag", 64'(rsp_tag), 64'd3);
        eval_and_advance();
        settle(); check("t1_once", 64'(rsp_valid), 64'd0); eval_and_advance();
        reset = 1'b1; tick(); reset = 1'b0;

        // Both lanes at once after reset: lane 0 first.
        set_lane(0, 64'h100, 2'b01, 6'd8, 4'd1);
        set_lane(1, 64'h1, 2'b00, 6'd63, 4'd2);
        settle();
        check("t2_r0", 64'(req0_ready), 64'd1);
        check("t2_r1", 64'(req1_ready), 64'd0);
        eval_and_advance();
        lv[0] = 1'b0;
        settle(); check("t2_r1b", 64'(req1_ready), 64'd1); eval_and_advance();
        lv[1] = 1'b0;
        settle(); check("t2_d0", rsp_data, 64'h1); eval_and_advance();
        settle();
        check("t2_d1", rsp_data, 64'h8000_0000_0000_0000);
        check("t2_id1", 64'(rsp_id), 64'd1);
        eval_and_advance();

        // Both lanes held valid: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 2; l++) begin
                if (!lv[l] || acc[l]) set_lane(l, 64'(i * 16 + l), 2'b11, 6'd0, 4'(i * 2 + l));
            end
            settle();
            check("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            eval_and_advance();
        end
        lv[0] = 1'b0; lv[1] = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // sra sign fill and pass-through kind.
        set_lane(1, 64'h8000_0000_0000_0000, 2'b10, 6'd4, 4'd5);
        tick();
        lv[1] = 1'b0;
        set_lane(0, 64'hDEAD, 2'b11, 6'd9, 4'd6);
        tick();
        lv[0] = 1'b0;
        settle(); check("t4_sra", rsp_data, 64'hF800_0000_0000_0000); eval_and_advance();
        settle(); check("t4_pass", rsp_data, 64'hDEAD); eval_and_advance();

        // Flush: T op delivered, T+1 op squashed, no grant in flush cycle.
        set_lane(0, 64'h5, 2'b00, 6'd1, 4'd1);
        tick();
        set_lane(0, 64'h7, 2'b00, 6'd2, 4'd2);
        tick();
        set_lane(0, 64'h9, 2'b01, 6'd3, 4'd4);
        flush = 1'b1;
        settle();
        check("fl_ready", 64'(req0_ready), 64'd0);
        check("fl_valid", 64'(rsp_valid), 64'd1);
        check("fl_tag", 64'(rsp_tag), 64'd1);
        eval_and_advance();
        flush = 1'b0;
        settle();
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_drop", 64'(rsp_valid), 64'd0);
        eval_and_advance();
        lv[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-operation discards the op and restores the pointer.
        set_lane(0, 64'h3, 2'b00, 6'd5, 4'd7);
        tick();
        lv[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_lane(0, 64'h11, 2'b00, 6'd1, 4'd8);
        set_lane(1, 64'h22, 2'b01, 6'd1, 4'd9);
        settle();
        check("rs_valid", 64'(rsp_valid), 64'd0);
        check("rs_kind", 64'(sh_kind), 64'(2'b11));
        check("rs_ptr", 64'(req0_ready), 64'd1);
        eval_and_advance();
        lv[0] = 1'b0;
        settle(); check("rs_none", 64'(rsp_valid), 64'd0); eval_and_advance();
        lv[1] = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 1500; c++) begin
            for (int l = 0; l < 2; l++) begin
                if (!lv[l] || acc[l]) begin
                    lv[l]    = ($urandom_range(0, 99) < 70);
                    lval[l]  = rand_val();
                    lkind[l] = 2'($urandom_range(0, 3));
                    lsh[l]   = 6'($urandom_range(0, 63));
                    ltag[l]  = TAG_W'($urandom);
                end
            end
            flush = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 99) < 2);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
